// File: rtl/btn_debounce_pulse.sv
// Push-button synchroniser, debouncer and single-pulse generator with debounced level output.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_btn_d_s_o,
  output logic o_btn_level,
  output logic o_busy
);

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // The repeat parameters only size the shared counter width when auto-repeat is built in.
  localparam int unsigned MAX_PARAM = AUTOREPEAT ?
                                      max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) :
                                      DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_PARAM);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, s_btn_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             rep_phase_q, rep_phase_d;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q     <= 1'b0;
      s_btn_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      pulse_q     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_q      <= '0;
      rep_phase_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= i_btn_raw;
      s_btn_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_q      <= rcnt_d;
      rep_phase_q <= rep_phase_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (s_btn_q) state_d = PRESS_WAIT;
      PRESS_WAIT: begin
        if (!s_btn_q)              state_d = IDLE;
        else if (cnt_q == DEB_LAST) state_d = HELD;
      end
      HELD:         if (!s_btn_q) state_d = RELEASE_WAIT;
      RELEASE_WAIT: begin
        if (s_btn_q)               state_d = HELD;
        else if (cnt_q == DEB_LAST) state_d = IDLE;
      end
      default:      state_d = IDLE;
    endcase
  end

  // The compare value is reached exactly on the exit transition, so cnt never wraps.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: if (s_btn_q) cnt_d = '0;
      PRESS_WAIT: begin
        if (s_btn_q) begin
          if (cnt_q == DEB_LAST) begin
            level_d = 1'b1;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HELD: if (!s_btn_q) cnt_d = '0;
      RELEASE_WAIT: begin
        if (!s_btn_q) begin
          if (cnt_q == DEB_LAST) level_d = 1'b0;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase

`ifdef BTN_AUTOREPEAT_EN
    // Phase 0 waits out the initial delay, phase 1 paces the subsequent repeats.
    rcnt_d      = rcnt_q;
    rep_phase_d = rep_phase_q;
    if (state_q == HELD && s_btn_q) begin
      if (rcnt_q == (rep_phase_q ? PER_LAST : DLY_LAST)) begin
        pulse_d     = 1'b1;
        rcnt_d      = '0;
        rep_phase_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end else begin
      rcnt_d      = '0;
      rep_phase_d = 1'b0;
    end
`endif
  end

  always_comb begin
    o_btn_d_s_o = pulse_q;
    o_btn_level = level_q;
    o_busy      = (state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed self-checking bench for btn_debounce_pulse (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
module tb_btn_debounce_pulse;

  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic pulse, level, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn_raw  (btn_raw),
    .o_btn_d_s_o(pulse),
    .o_btn_level(level),
    .o_busy     (busy)
  );

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
    end
  endtask

  // Drive one raw sample, let one rising edge capture it, then settle before sampling.
  task automatic applyStimulus(input logic raw);
    btn_raw = raw;
    @(posedge clk);
    #1;
  endtask

  // Expected pulse h cycles after entering HELD while the button stays down.
  function automatic logic heldPulse(input int h);
    if (h == 0) return 1'b1;
    if (AUTOREPEAT && h >= RDLY && ((h - RDLY) % RPER) == 0) return 1'b1;
    return 1'b0;
  endfunction

  int bouncy_raw [16] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int bouncy_busy[16] = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};

  initial begin
    rst     = 1'b1;
    btn_raw = 1'b0;
    #12;
    checkOutput("reset_pulse", pulse, 1'b0);
    checkOutput("reset_level", level, 1'b0);
    checkOutput("reset_busy",  busy,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(1'b0);

    // Clean press held long enough to cover the auto-repeat schedule as well.
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("clean_pulse_k%0d", k), pulse, (k >= 7) ? heldPulse(k - 7) : 1'b0);
      checkOutput($sformatf("clean_level_k%0d", k), level, logic'(k >= 7));
      checkOutput($sformatf("clean_busy_k%0d", k),  busy,  logic'(k >= 3 && k <= 6));
    end

    for (int k = 1; k <= 8; k++) begin
      applyStimulus((k <= 2) ? 1'b0 : 1'b1);
      checkOutput($sformatf("relbounce_pulse_k%0d", k), pulse, 1'b0);
      checkOutput($sformatf("relbounce_level_k%0d", k), level, 1'b1);
      checkOutput($sformatf("relbounce_busy_k%0d", k),  busy,  logic'(k == 3 || k == 4));
    end

    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("release_pulse_k%0d", k), pulse, 1'b0);
      checkOutput($sformatf("release_level_k%0d", k), level, logic'(k < 7));
      checkOutput($sformatf("release_busy_k%0d", k),  busy,  logic'(k >= 3 && k <= 6));
    end

    for (int k = 1; k <= 16; k++) begin
      applyStimulus(logic'(bouncy_raw[k-1]));
      checkOutput($sformatf("bouncy_pulse_k%0d", k), pulse, logic'(k == 12));
      checkOutput($sformatf("bouncy_level_k%0d", k), level, logic'(k >= 12));
      checkOutput($sformatf("bouncy_busy_k%0d", k),  busy,  logic'(bouncy_busy[k-1]));
    end

    for (int k = 1; k <= 8; k++) applyStimulus(1'b0);
    checkOutput("idle_before_rst_level", level, 1'b0);
    checkOutput("idle_before_rst_busy",  busy,  1'b0);

    // Press reaches cnt=2 in PRESS_WAIT, then reset lands between clock edges.
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1);
    checkOutput("prerst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_pulse", pulse, 1'b0);
    checkOutput("midrst_level", level, 1'b0);
    checkOutput("midrst_busy",  busy,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("postrst_pulse_k%0d", k), pulse, logic'(k == 7));
      checkOutput($sformatf("postrst_level_k%0d", k), level, logic'(k >= 7));
      checkOutput($sformatf("postrst_busy_k%0d", k),  busy,  logic'(k >= 3 && k <= 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
